// File: rtl/int_ctrl.sv
// int_ctrl: edge-latched, fixed-priority interrupt controller for the jacaranda-8 core.
// It provides a memory-mapped EN/VBASE/PEND window and issues a one-cycle request
// that is held in service until an end-of-interrupt (EOI) write.
module int_ctrl #(
    parameter int unsigned N_SRC     = 4,
    parameter logic [7:0]  ADDR_BASE = 8'hF0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mem_w_en,
    input  logic [7:0]       mem_addr,
    input  logic [7:0]       mem_w_data,
    output logic [7:0]       r_data,
    output logic             int_req,
    output logic [7:0]       int_en,
    output logic [7:0]       int_vec,
    output logic             in_service
);

    localparam int unsigned ID_W    = 3;
    localparam logic [7:0]  EN_MASK = 8'((9'd1 << (N_SRC + 1)) - 9'd1);
    localparam logic [7:0]  A_EN    = ADDR_BASE;
    localparam logic [7:0]  A_VBASE = ADDR_BASE + 8'd1;
    localparam logic [7:0]  A_PEND  = ADDR_BASE + 8'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          en_q, en_d;
    logic [7:0]          vbase_q, vbase_d;
    logic [N_SRC-1:0]    pend_q, pend_d;
    logic [N_SRC-1:0]    prev_q, prev_d;
    logic [ID_W-1:0]     src_id_q, src_id_d;
    logic [7:0]          vec_q, vec_d;
    logic                req_q, req_d;
    logic                insvc_q, insvc_d;

    logic [N_SRC-1:0]    rise;
    logic [N_SRC-1:0]    elig;
    logic [N_SRC-1:0]    clr_mask;
    logic [ID_W-1:0]     win;
    logic                any_elig;
    logic                eoi;

    // Edge detect and eligibility; the lowest eligible index wins
    always_comb begin
        rise     = irq_src & ~prev_q;
        elig     = pend_q & en_q[N_SRC:1];
        any_elig = |elig;
        win      = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = ID_W'(i);
            end
        end
    end

    // Next-state: register writes, pending update, request sequencing
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        vbase_d  = vbase_q;
        prev_d   = irq_src;
        src_id_d = src_id_q;
        vec_d    = vec_q;
        clr_mask = '0;
        eoi      = mem_w_en && (mem_addr == A_PEND) && (state_q == S_SERVICE);

        if (mem_w_en && (mem_addr == A_EN)) begin
            en_d = mem_w_data & EN_MASK;
        end
        if (mem_w_en && (mem_addr == A_VBASE)) begin
            vbase_d = mem_w_data;
        end

        if (eoi) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (src_id_q == ID_W'(i)) begin
                    clr_mask[i] = 1'b1;
                end
            end
        end
        // A new rise on the in-service source in the EOI cycle keeps it pending
        pend_d = (pend_q & ~clr_mask) | rise;

        case (state_q)
            S_IDLE: begin
                if (en_q[0] && any_elig) begin
                    state_d  = S_REQ;
                    src_id_d = win;
                    vec_d    = vbase_q + 8'({win, 2'b00});
                end
            end
            S_REQ: begin
                state_d = S_SERVICE;
            end
            S_SERVICE: begin
                if (eoi) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d   = (state_d == S_REQ);
        insvc_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        // Input history follows irq_src through reset so levels held across reset are not edges
        prev_q <= prev_d;
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= '0;
            vbase_q  <= '0;
            pend_q   <= '0;
            src_id_q <= '0;
            vec_q    <= '0;
            req_q    <= 1'b0;
            insvc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            vbase_q  <= vbase_d;
            pend_q   <= pend_d;
            src_id_q <= src_id_d;
            vec_q    <= vec_d;
            req_q    <= req_d;
            insvc_q  <= insvc_d;
        end
    end

    // Combinational register read-back; zero outside the window
    always_comb begin
        r_data = 8'h00;
        if (mem_addr == A_EN) begin
            r_data = en_q;
        end else if (mem_addr == A_VBASE) begin
            r_data = vbase_q;
        end else if (mem_addr == A_PEND) begin
            r_data = 8'(pend_q);
        end
    end

    assign int_req    = req_q;
    assign int_en     = en_q;
    assign int_vec    = vec_q;
    assign in_service = insvc_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with an expected-value queue and immediate assertions.
module tb_int_ctrl;

    localparam int unsigned N_SRC = 4;

    logic             clock;
    logic             reset;
    logic [N_SRC-1:0] irq_src;
    logic             mem_w_en;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_w_data;
    logic [7:0]       r_data;
    logic             int_req;
    logic [7:0]       int_en;
    logic [7:0]       int_vec;
    logic             in_service;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int_ctrl #(.N_SRC(N_SRC), .ADDR_BASE(8'hF0)) dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .r_data     (r_data),
        .int_req    (int_req),
        .int_en     (int_en),
        .int_vec    (int_vec),
        .in_service (in_service)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        mem_w_en   = 1'b1;
        mem_addr   = addr;
        mem_w_data = data;
        tick();
        mem_w_en   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] data);
        mem_addr = addr;
        #1;
        data = r_data;
    endtask

    logic [7:0] rv;

    initial begin
        reset      = 1'b0;
        irq_src    = 4'b0011;
        mem_w_en   = 1'b0;
        mem_addr   = 8'h00;
        mem_w_data = 8'h00;

        // Reset with sources held high
        tick(); tick(); tick();
        expect_val("rst_int_req", 8'h00);    chk(8'(int_req));
        expect_val("rst_in_service", 8'h00); chk(8'(in_service));
        expect_val("rst_int_en", 8'h00);     chk(int_en);
        expect_val("rst_int_vec", 8'h00);    chk(int_vec);
        reset = 1'b1;
        tick(); tick();
        expect_val("post_rst_pend", 8'h00);  rd(8'hF2, rv); chk(rv);
        expect_val("post_rst_req", 8'h00);   chk(8'(int_req));
        irq_src = 4'b0000;
        tick();

        // Single source 0 request
        wr(8'hF0, 8'h03);
        wr(8'hF1, 8'h40);
        expect_val("en_readback", 8'h03);    rd(8'hF0, rv); chk(rv);
        expect_val("vbase_readback", 8'h40); rd(8'hF1, rv); chk(rv);
        irq_src = 4'b0001;
        expect_val("s0_req_edge0", 8'h00);
        tick(); chk(8'(int_req));
        expect_val("s0_req_hi", 8'h01);
        expect_val("s0_vec", 8'h40);
        expect_val("s0_insvc", 8'h01);
        tick(); chk(8'(int_req)); chk(int_vec); chk(8'(in_service));
        irq_src = 4'b0000;
        expect_val("s0_req_lo", 8'h00);
        expect_val("s0_insvc_hold", 8'h01);
        tick(); chk(8'(int_req)); chk(8'(in_service));
        expect_val("s0_pend_svc", 8'h01);    rd(8'hF2, rv); chk(rv);
        wr(8'hF2, 8'h00);
        expect_val("s0_eoi_insvc", 8'h00);   chk(8'(in_service));
        expect_val("s0_eoi_pend", 8'h00);    rd(8'hF2, rv); chk(rv);
        expect_val("s0_no_rereq", 8'h00);
        tick(); chk(8'(int_req));

        // Simultaneous rise on sources 0 and 1
        wr(8'hF0, 8'h07);
        irq_src = 4'b0011;
        tick();
        expect_val("pri_first_req", 8'h01);
        expect_val("pri_first_vec", 8'h40);
        tick(); chk(8'(int_req)); chk(int_vec);
        irq_src = 4'b0000;
        tick();
        wr(8'hF2, 8'h00);
        expect_val("pri_pend_after_eoi", 8'h02); rd(8'hF2, rv); chk(rv);
        expect_val("pri_second_req", 8'h01);
        expect_val("pri_second_vec", 8'h44);
        tick(); chk(8'(int_req)); chk(int_vec);
        tick();
        wr(8'hF2, 8'h00);
        expect_val("pri_pend_clear", 8'h00); rd(8'hF2, rv); chk(rv);

        // Vector wrap-around and VBASE write while in service
        wr(8'hF1, 8'hFC);
        wr(8'hF0, 8'h09);
        irq_src = 4'b0100;
        tick();
        expect_val("wrap_req", 8'h01);
        expect_val("wrap_vec", 8'h04);
        tick(); chk(8'(int_req)); chk(int_vec);
        irq_src = 4'b0000;
        tick();
        wr(8'hF1, 8'h00);
        expect_val("vbase_write_svc_vec", 8'h04); chk(int_vec);
        wr(8'hF2, 8'h00);

        // Rise on the in-service source during EOI keeps it pending
        wr(8'hF0, 8'h03);
        wr(8'hF1, 8'h40);
        irq_src = 4'b0001;
        tick();
        tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0001;
        wr(8'hF2, 8'h00);
        expect_val("eoi_rise_pend", 8'h01);  rd(8'hF2, rv); chk(rv);
        expect_val("eoi_rise_insvc", 8'h00); chk(8'(in_service));
        irq_src = 4'b0000;
        expect_val("eoi_rise_rereq", 8'h01);
        expect_val("eoi_rise_vec", 8'h40);
        tick(); chk(8'(int_req)); chk(int_vec);
        tick();
        wr(8'hF2, 8'h00);

        // Global disable blocks the request; enabling releases it
        wr(8'hF0, 8'h02);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        expect_val("gdis_pend", 8'h01);      rd(8'hF2, rv); chk(rv);
        expect_val("gdis_no_req", 8'h00);    chk(8'(int_req));
        wr(8'hF0, 8'h03);
        expect_val("gen_req_not_yet", 8'h00); chk(8'(int_req));
        expect_val("gen_req", 8'h01);
        tick(); chk(8'(int_req));

        // EOI in REQ is ignored
        wr(8'hF2, 8'h00);
        expect_val("eoi_in_req_pend", 8'h01);  rd(8'hF2, rv); chk(rv);
        expect_val("eoi_in_req_insvc", 8'h01); chk(8'(in_service));

        // Global disable during service does not abort
        wr(8'hF0, 8'h02);
        expect_val("gdis_svc_insvc", 8'h01);   chk(8'(in_service));
        expect_val("out_of_window", 8'h00);    rd(8'hF3, rv); chk(rv);
        wr(8'hF2, 8'h00);
        expect_val("gdis_svc_eoi", 8'h00);     chk(8'(in_service));

        // Reset in the middle of a sequence
        wr(8'hF0, 8'h03);
        irq_src = 4'b0011;
        tick();
        tick();
        expect_val("mid_req_before_rst", 8'h01); chk(8'(int_req));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_val("mid_rst_req", 8'h00);    chk(8'(int_req));
        expect_val("mid_rst_insvc", 8'h00);  chk(8'(in_service));
        expect_val("mid_rst_pend", 8'h00);   rd(8'hF2, rv); chk(rv);
        expect_val("mid_rst_en", 8'h00);     chk(int_en);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
